// File: rtl/count_pulse_gen_if.sv
// rtl/count_pulse_gen_if.sv - button/event line and count-enable pulse bundle for count_pulse_gen
interface count_pulse_gen_if;
  logic btn_in;
  logic enable;
  logic btn_level;
  logic pulse_out;

  modport master (
    output btn_in,
    output enable,
    input  btn_level,
    input  pulse_out
  );

  modport slave (
    input  btn_in,
    input  enable,
    output btn_level,
    output pulse_out
  );
endinterface

// File: rtl/count_pulse_gen.sv
// rtl/count_pulse_gen.sv - synchronize, debounce and edge-detect a button into count-enable pulses
// Auto-repeat while held is built only when COUNT_PULSE_AUTO_REPEAT_EN is defined.
module count_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3
) (
  input logic             clk,
  input logic             reset,
  count_pulse_gen_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("count_pulse_gen: illegal parameter value");
  end

  logic [1:0]      sync_q;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            btn_level_q;
  logic            pulse_q;
  logic            db_mismatch;
  logic            db_hit;
  logic            level_rise;
  logic            level_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.btn_in};
    end
  end

  assign btn_sync    = sync_q[1];
  assign db_mismatch = (btn_sync != btn_level_q);
  assign db_hit      = db_mismatch && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign level_rise  = db_hit && !btn_level_q;
  assign level_fall  = db_hit && btn_level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_level_q <= 1'b0;
    end else if (!db_mismatch) begin
      db_cnt <= '0;
    end else if (db_hit) begin
      db_cnt      <= '0;
      btn_level_q <= ~btn_level_q;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

`ifdef COUNT_PULSE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  state_t           state;
  logic [RPT_W-1:0] rpt_tmr;

  // Release is checked first so a timer expiring on the release cycle never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rpt_tmr <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (level_fall) begin
        state   <= IDLE;
        rpt_tmr <= '0;
      end else begin
        case (state)
          IDLE: begin
            rpt_tmr <= '0;
            if (level_rise) begin
              state   <= HELD;
              pulse_q <= bus.enable;
            end
          end
          HELD: begin
            if (rpt_tmr == RPT_W'(REPEAT_DELAY - 1)) begin
              state   <= REPEAT;
              rpt_tmr <= '0;
              pulse_q <= bus.enable;
            end else begin
              rpt_tmr <= rpt_tmr + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_tmr == RPT_W'(REPEAT_PERIOD - 1)) begin
              rpt_tmr <= '0;
              pulse_q <= bus.enable;
            end else begin
              rpt_tmr <= rpt_tmr + RPT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rpt_tmr <= '0;
          end
        endcase
      end
    end
  end
`else
  typedef enum logic {IDLE, HELD} state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (level_fall) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (level_rise) begin
              state   <= HELD;
              pulse_q <= bus.enable;
            end
          end
          HELD: begin
            state <= HELD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
`endif

  assign bus.btn_level = btn_level_q;
  assign bus.pulse_out = pulse_q;

endmodule

// File: tb/tb_count_pulse_gen.sv
// tb/tb_count_pulse_gen.sv - directed self-checking bench for count_pulse_gen
module tb_count_pulse_gen;

  logic clk = 1'b0;
  logic reset;

  count_pulse_gen_if bus();

  count_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int plog[$];

`ifdef COUNT_PULSE_AUTO_REPEAT_EN
  int exp_hold[] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
  int exp_gate[] = '{10};
  int exp_rst[]  = '{10, 19};
`else
  int exp_hold[] = '{0};
  int exp_gate[] = '{};
  int exp_rst[]  = '{19};
`endif

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.pulse_out === 1'b1) plog.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_log(input string tag, input int base, input int exp[]);
    chk({tag, "_count"}, plog.size(), exp.size());
    foreach (exp[i]) begin
      chk({tag, "_at"}, (i < plog.size()) ? plog[i] - base : -1, exp[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p;
    int fall_k;
    int rise_k;
    int bounce[] = '{1, 0, 1, 1, 0, 1, 1, 1, 0};

    reset      = 1'b1;
    bus.btn_in = 1'b1;
    bus.enable = 1'b1;

    // reset held with the button already high
    repeat (3) begin
      tick();
      chk("rst_level", int'(bus.btn_level), 0);
      chk("rst_pulse", int'(bus.pulse_out), 0);
    end
    reset = 1'b0;
    plog.delete();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_level", int'(bus.btn_level), (k >= 6) ? 1 : 0);
      chk("t1_pulse", int'(bus.pulse_out), (k == 6) ? 1 : 0);
    end

    // release, then bounce shorter than the debounce window
    bus.btn_in = 1'b0;
    repeat (10) tick();
    chk("rel_level", int'(bus.btn_level), 0);
    chk("rel_nopulse", plog.size(), 1);
    plog.delete();
    foreach (bounce[i]) begin
      bus.btn_in = bounce[i][0];
      tick();
    end
    bus.btn_in = 1'b1;
    n0 = cyc;
    repeat (5) tick();
    chk("t2_bounce_quiet", plog.size(), 0);
    chk("t2_level_early", int'(bus.btn_level), 0);
    tick();
    chk("t2_level", int'(bus.btn_level), 1);
    chk("t2_at", (plog.size() > 0) ? plog[0] : -1, n0 + 6);
    p = n0 + 6;

    // hold, release, and observe the debounced fall
    while (cyc < p + 30) tick();
    bus.btn_in = 1'b0;
    fall_k = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.btn_level == 1'b0 && fall_k == 0) fall_k = k;
    end
    chk("t3_fall", fall_k, 6);
    repeat (8) tick();
    chk_log("t3_hold", p, exp_hold);

    // press with enable low, enable raised mid-hold
    plog.delete();
    bus.enable = 1'b0;
    bus.btn_in = 1'b1;
    n0 = cyc;
    p = n0 + 6;
    while (cyc < p + 5) tick();
    chk("t5_no_press_pulse", plog.size(), 0);
    chk("t5_level", int'(bus.btn_level), 1);
    bus.enable = 1'b1;
    while (cyc < p + 11) tick();
    chk_log("t5_gate", p, exp_gate);

    // reset lands on P+12 with the button still held
    reset = 1'b1;
    tick();
    chk("t6_rst_pulse0", int'(bus.pulse_out), 0);
    chk("t6_rst_level0", int'(bus.btn_level), 0);
    tick();
    chk("t6_rst_pulse1", int'(bus.pulse_out), 0);
    chk("t6_rst_level1", int'(bus.btn_level), 0);
    reset = 1'b0;
    rise_k = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.pulse_out == 1'b1 && rise_k == 0) rise_k = k;
    end
    chk("t6_repress", rise_k, 6);
    chk("t6_level", int'(bus.btn_level), 1);
    chk_log("t6_log", p, exp_rst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
